// File: rtl/audio_pkg.sv
// Shared audio types and helpers for the PCM input path.
package audio_pkg;

  typedef logic signed [15:0] pcm_t;

  localparam pcm_t PCM_MAX = 16'h7FFF;
  localparam pcm_t PCM_MIN = 16'h8000;

  // Register width a sinc^3 decimator needs for 1-bit input: 3*log2(R) bits of
  // growth on top of the single input bit.
  function automatic int unsigned cic_width(input int unsigned log2_r);
    return 3 * log2_r + 1;
  endfunction

endpackage

// File: rtl/sd_cic_integrator.sv
// One CIC integrator stage: a free-running modular accumulator with enable.
module sd_cic_integrator #(
  parameter int unsigned Width = 25
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [Width-1:0] inc_i,
  output logic [Width-1:0] acc_o
);

  logic [Width-1:0] acc_q, acc_d;

  // Accumulate on enabled cycles; wrap-around is part of the CIC arithmetic.
  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      acc_d = acc_q + inc_i;
    end
  end

  // Accumulator register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/delta_sigma_adc_decimator.sv
// Delta-sigma ADC back end: samples the comparator bitstream, feeds it back to
// the modulator RC, and decimates it with a sinc^3 CIC to signed 16-bit PCM.
module delta_sigma_adc_decimator
  import audio_pkg::*;
#(
  parameter int unsigned LOG2_R = 8,
  parameter int unsigned PCM_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             os_en,
  input  logic             sd_in,
  output logic             fb_out,
  output logic [PCM_W-1:0] pcm_out,
  output logic             pcm_valid
);

  localparam int unsigned W = cic_width(LOG2_R);

  // Mid-scale of the comb output (R^3 / 2): zero-density maps to -full-scale.
  localparam logic [W-1:0]      CombOffset = {2'b01, {(W-2){1'b0}}};
  localparam logic [LOG2_R-1:0] CntLast    = '1;
  localparam logic [1:0]        PrimeDone  = 2'd3;

  // Input sampling and feedback drive.
  logic sd_q;

  // Integrator outputs.
  logic [W-1:0] i1, i2, i3;

  // Decimation counter and comb pipeline strobes.
  logic [LOG2_R-1:0] cnt_q, cnt_d;
  logic              dec_strb_q, dec_strb_d;
  logic              strb1_q, strb2_q, strb3_q;

  // Comb stages and their one-pass-delayed copies.
  logic [W-1:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic [W-1:0] i3_dly_q, i3_dly_d, c1_dly_q, c1_dly_d, c2_dly_q, c2_dly_d;

  // Output stage.
  logic [W-1:0]     diff;
  logic             sat;
  logic [PCM_W-1:0] pcm_next;
  logic [PCM_W-1:0] pcm_q, pcm_d;
  logic             pcm_valid_q, pcm_valid_d;
  logic [1:0]       prime_q, prime_d;
  logic             unused_diff;

  // Capture the comparator bit only on oversample strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sd_q <= 1'b0;
    end else if (os_en) begin
      sd_q <= sd_in;
    end
  end

  assign fb_out = sd_q;

  // Pipelined integrator chain: each stage adds the previous stage's old value.
  sd_cic_integrator #(
    .Width (W)
  ) u_int1 (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (os_en),
    .inc_i ({{(W-1){1'b0}}, sd_q}),
    .acc_o (i1)
  );

  sd_cic_integrator #(
    .Width (W)
  ) u_int2 (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (os_en),
    .inc_i (i1),
    .acc_o (i2)
  );

  sd_cic_integrator #(
    .Width (W)
  ) u_int3 (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (os_en),
    .inc_i (i2),
    .acc_o (i3)
  );

  // Decimation counter; flag the last sample of each frame.
  always_comb begin
    cnt_d      = cnt_q;
    dec_strb_d = 1'b0;
    if (os_en) begin
      cnt_d      = cnt_q + 1'b1;
      dec_strb_d = (cnt_q == CntLast);
    end
  end

  // Comb next-state: each stage moves only on its own strobe.
  always_comb begin
    c1_d     = c1_q;
    c2_d     = c2_q;
    c3_d     = c3_q;
    i3_dly_d = i3_dly_q;
    c1_dly_d = c1_dly_q;
    c2_dly_d = c2_dly_q;
    if (dec_strb_q) begin
      c1_d     = i3 - i3_dly_q;
      i3_dly_d = i3;
    end
    if (strb1_q) begin
      c2_d     = c1_q - c1_dly_q;
      c1_dly_d = c1_q;
    end
    if (strb2_q) begin
      c3_d     = c2_q - c2_dly_q;
      c2_dly_d = c2_q;
    end
  end

  // Map the comb result to PCM: remove mid-scale offset, clip the single
  // out-of-range code (all-ones input), keep the top PCM_W magnitude bits.
  always_comb begin
    diff     = c3_q - CombOffset;
    sat      = ~diff[W-1] & diff[W-2];
    pcm_next = sat ? PCM_W'(PCM_MAX) : diff[W-2 -: PCM_W];
  end

  assign unused_diff = ^diff[W-PCM_W-2:0];

  // Prime gating: the first three comb passes after reset are discarded.
  always_comb begin
    prime_d     = prime_q;
    pcm_d       = pcm_q;
    pcm_valid_d = 1'b0;
    if (strb3_q) begin
      if (prime_q != PrimeDone) begin
        prime_d = prime_q + 2'd1;
      end else begin
        pcm_d       = pcm_next;
        pcm_valid_d = 1'b1;
      end
    end
  end

  // Counter, strobe pipeline, comb, prime and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      dec_strb_q  <= 1'b0;
      strb1_q     <= 1'b0;
      strb2_q     <= 1'b0;
      strb3_q     <= 1'b0;
      c1_q        <= '0;
      c2_q        <= '0;
      c3_q        <= '0;
      i3_dly_q    <= '0;
      c1_dly_q    <= '0;
      c2_dly_q    <= '0;
      prime_q     <= 2'd0;
      pcm_q       <= '0;
      pcm_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dec_strb_q  <= dec_strb_d;
      strb1_q     <= dec_strb_q;
      strb2_q     <= strb1_q;
      strb3_q     <= strb2_q;
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      c3_q        <= c3_d;
      i3_dly_q    <= i3_dly_d;
      c1_dly_q    <= c1_dly_d;
      c2_dly_q    <= c2_dly_d;
      prime_q     <= prime_d;
      pcm_q       <= pcm_d;
      pcm_valid_q <= pcm_valid_d;
    end
  end

  assign pcm_out   = pcm_q;
  assign pcm_valid = pcm_valid_q;

endmodule

// File: tb/tb_delta_sigma_adc_decimator.sv
// Directed bench for the delta-sigma decimator: periodic bitstreams with known
// density, checked for PCM value, prime suppression, latency and spacing.
module tb_delta_sigma_adc_decimator;
  import audio_pkg::*;

  localparam int R = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        os_en = 1'b0;
  logic        sd_in = 1'b0;
  logic        fb_out;
  logic [15:0] pcm_out;
  logic        pcm_valid;

  int n_checks = 0;
  int n_bad    = 0;

  // Stimulus state: bit pattern (bit 0 first), os_en divider, model of fb_out.
  logic [3:0] pat = 4'b0000;
  int         plen = 1;
  int         pidx = 0;
  int         os_div = 1;
  int         phase = 0;
  int         cyc = 0;
  logic       last_bit = 1'b0;

  delta_sigma_adc_decimator #(
    .LOG2_R (8),
    .PCM_W  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .os_en     (os_en),
    .sd_in     (sd_in),
    .fb_out    (fb_out),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after posedge.
  task automatic run_clk();
    @(negedge clk);
    rst = 1'b0;
    if (phase == 0) begin
      os_en = 1'b1;
      sd_in = pat[pidx];
    end else begin
      os_en = 1'b0;
      sd_in = ~last_bit;  // must be ignored while os_en is low
    end
    phase = (phase + 1 == os_div) ? 0 : phase + 1;
    @(posedge clk);
    #1;
    if (os_en) begin
      last_bit = sd_in;
      pidx = (pidx + 1 == plen) ? 0 : pidx + 1;
    end
    cyc++;
  endtask

  // One reset cycle (with a live strobe and a 1 on the input), then check outputs.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst   = 1'b1;
    os_en = 1'b1;
    sd_in = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, "_rst_fb"}, 32'(fb_out), 32'd0);
    check_eq({tag, "_rst_pcm"}, 32'(pcm_out), 32'h0);
    check_eq({tag, "_rst_vld"}, 32'(pcm_valid), 32'd0);
    cyc      = 0;
    phase    = 0;
    pidx     = 0;
    last_bit = 1'b0;
  endtask

  task automatic set_mode(input logic [3:0] p, input int len, input int div);
    pat    = p;
    plen   = len;
    os_div = div;
  endtask

  // Collect nv valid pulses after a reset; check first-pulse latency, spacing,
  // value and feedback bit at each.
  task automatic run_frames(input string tag, input int nv, input logic [15:0] exp_val,
                            input int exp_first, input int exp_space);
    int got;
    int last;
    int budget;
    got    = 0;
    last   = 0;
    budget = exp_first + nv * exp_space + 64;
    for (int c = 0; c < budget && got < nv; c++) begin
      run_clk();
      if (pcm_valid) begin
        if (got == 0) check_eq({tag, "_first"}, 32'(cyc), 32'(exp_first));
        else check_eq({tag, "_space"}, 32'(cyc - last), 32'(exp_space));
        check_eq({tag, "_pcm"}, 32'(pcm_out), 32'(exp_val));
        check_eq({tag, "_fb"}, 32'(fb_out), 32'(last_bit));
        last = cyc;
        got++;
      end
    end
    check_eq({tag, "_nvalid"}, 32'(got), 32'(nv));
  endtask

  initial begin
    // All ones: saturates at positive full scale.
    set_mode(4'b1111, 1, 1);
    do_reset("ones");
    run_frames("ones", 3, PCM_MAX, 4 * R + 4, R);

    // All zeros: negative full scale.
    set_mode(4'b0000, 1, 1);
    do_reset("zeros");
    run_frames("zeros", 3, PCM_MIN, 4 * R + 4, R);

    // 50% density: exactly zero.
    set_mode(4'b0001, 2, 1);
    do_reset("alt");
    run_frames("alt", 3, 16'h0000, 4 * R + 4, R);

    // 75% density.
    set_mode(4'b0111, 4, 1);
    do_reset("d75");
    run_frames("d75", 3, 16'h4000, 4 * R + 4, R);

    // Mid-frame reset: partial frame discarded, prime restarts.
    for (int k = 0; k < 100; k++) run_clk();
    do_reset("midrst");
    run_frames("midrst", 2, 16'h4000, 4 * R + 4, R);

    // 25% density.
    set_mode(4'b0001, 4, 1);
    do_reset("d25");
    run_frames("d25", 3, 16'hC000, 4 * R + 4, R);

    // Sparse oversample strobe (every 3rd clk), 75% density.
    set_mode(4'b0111, 4, 3);
    do_reset("slow");
    run_frames("slow", 3, 16'h4000, 12 * R + 2, 3 * R);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/delta_sigma_adc_decimator.md
Name: delta_sigma_adc_decimator

Overview:
Receive-side counterpart of delta_sigma_dac. Samples a 1-bit delta-sigma bitstream from an external comparator and returns the registered bit as the RC-feedback drive. Decimates the bitstream with a 3rd-order CIC (sinc^3) filter to 16-bit signed PCM with a one-cycle valid strobe. Sits at the audio input; its PCM feeds the processing chain.

Parameters:
LOG2_R, 8, log2 of decimation ratio R (R = 256); legal range 6..10
PCM_W, 16, output sample width (fixed 16; not user-tunable)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous, active-high reset
os_en  in  1  oversample strobe; the bitstream is sampled on clk edges where os_en=1
sd_in  in  1  comparator bitstream (already synchronised upstream)
fb_out  out  1  registered sd_in, drives the modulator feedback RC
pcm_out  out  16  signed two's-complement PCM sample
pcm_valid  out  1  one-clk pulse; pcm_out is new and held until the next pulse

Behaviour:
- Reset (rst=1 at a clk edge): fb_out=0, pcm_out=16'h0000, pcm_valid=0; all integrators, combs, counters, pipeline strobes and the prime counter are cleared. Reset mid-frame discards the partial frame.
- W = 3*LOG2_R+1 bits (25 at default). All integrator and comb arithmetic is unsigned mod 2^W; wrap-around is intentional and must not be saturated.
- On an os_en cycle:
  - sd_q <= sd_in; fb_out = sd_q.
  - Pipelined integrators update from previous register values: i1 += sd_q (zero-extended), i2 += i1, i3 += i2.
  - Decimation counter cnt (LOG2_R bits) increments and wraps at R-1.
- When os_en=1 and cnt=R-1, dec_strb is registered high for one clk.
- Comb pipeline advances only on its strobes:
  - t+1 (dec_strb): c1 = i3 - i3_d; i3_d <= i3.
  - t+2: c2 = c1 - c1_d.
  - t+3: c3 = c2 - c2_d.
  - t+4: output stage (below).
- Output stage:
  - diff = c3 - 2^(W-2), treated as signed W bits.
  - diff >= 2^(W-2) gives pcm_out = 16'h7FFF (saturate).
  - Otherwise pcm_out = diff[W-2 -: 16].
- Latency: pcm_valid pulses exactly 4 clk after the os_en cycle with cnt=R-1.
- os_en=0: no integrator, counter or fb_out change. The comb pipeline still drains in flight.
- os_en may be high every clk; R>=64 guarantees that comb-pipeline passes never overlap.
- Prime: the first 3 comb results after reset are settling garbage. A 2-bit prime counter suppresses pcm_valid and pcm_out updates for those 3 passes; the 4th pass and later are output.
- Mapping: bit density d gives pcm ~ (2d-1)*32768, saturated at 0x7FFF.

Decomposition:
- Package audio_pkg:
  - typedef pcm_t (logic signed [15:0])
  - PCM_MAX=16'h7FFF, PCM_MIN=16'h8000
  - function cic_width(log2_r) returning 3*log2_r+1
- One sub-module, sd_cic_integrator: W-bit accumulator with enable and sync reset, instantiated 3 times.
- Combs, counter, prime logic and output stage stay inline.

Test Plan:
1. os_en every clk, sd_in constant 1, after 4 frames -> every pcm_valid carries 16'h7FFF (saturated); fb_out=1.
2. sd_in constant 0 -> pcm_out=16'h8000 on every valid after prime.
3. sd_in alternating 1,0 -> pcm_out=16'h0000 exactly after prime; pulses spaced 256 clk apart.
4. sd_in pattern 1,1,1,0 repeating -> pcm_out=16'h4000; pattern 1,0,0,0 -> 16'hC000.
5. os_en=1 every 3rd clk with the 1,1,1,0 pattern -> same 16'h4000; valid spacing 768 clk; valid 4 clk after the cnt=R-1 strobe; integrators frozen while os_en=0.
6. rst=1 for one clk mid-frame during test 4 -> next clk outputs at reset values; 3 suppressed passes; first valid 4*256+4 clk after reset release, value 16'h4000.
